// File: rtl/alu_seq_ctrl.sv
// Issue/writeback controller for a 3-bit-opcode ALU: accepts instructions, reads an
// 8-entry register file, drives the ALU for one cycle and writes the result back.
module alu_seq_ctrl #(
  parameter int WIDTH    = 15,
  parameter int OP_WIDTH = 3,
  parameter int NREGS    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  input  logic [15:0]         instr,
  output logic                instr_ready,
  output logic [OP_WIDTH-1:0] alu_op,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  input  logic [WIDTH:0]      alu_result,
  output logic                res_valid,
  output logic [2:0]          res_rd,
  output logic [WIDTH-1:0]    res_data,
  output logic                carry_flag,
  output logic                zero_flag,
  output logic                illegal,
  input  logic [2:0]          dbg_addr,
  output logic [WIDTH-1:0]    dbg_data
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_e;
  typedef enum logic [2:0] {
    OP_NOP = 3'b000, OP_ADD = 3'b001, OP_SUB = 3'b010, OP_AND = 3'b011,
    OP_OR  = 3'b100, OP_XOR = 3'b101, OP_LOADI = 3'b110, OP_ILL = 3'b111
  } op_e;

  state_e            state_q, state_d;
  logic [15:0]       instr_q, instr_d;
  logic [WIDTH-1:0]  alu_a_q, alu_a_d;
  logic [WIDTH-1:0]  alu_b_q, alu_b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;
  logic              illegal_q, illegal_d;
  logic [WIDTH-1:0]  regs_q [NREGS];
  logic [WIDTH-1:0]  regs_d [NREGS];

  logic [2:0]        op_f, rd_f, rs1_f, rs2_f;
  logic [WIDTH-1:0]  wb_data;

  assign op_f  = instr_q[15:13];
  assign rd_f  = instr_q[12:10];
  assign rs1_f = instr_q[9:7];
  assign rs2_f = instr_q[6:4];

  // LOADI bypasses the ALU entirely; its immediate is zero-extended at writeback.
  assign wb_data = (op_f == OP_LOADI) ? {{(WIDTH-10){1'b0}}, instr_q[9:0]} : res_q;

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    res_d     = res_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    regs_d    = regs_q;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          case (instr[15:13])
            OP_NOP:  ;
            OP_ILL:  illegal_d = 1'b1;
            default: state_d = DECODE;
          endcase
        end
      end
      DECODE: begin
        alu_a_d = regs_q[rs1_f];
        alu_b_d = regs_q[rs2_f];
        state_d = (op_f == OP_LOADI) ? WB : EXEC;
      end
      EXEC: begin
        res_d   = alu_result[WIDTH-1:0];
        carry_d = alu_result[WIDTH];
        zero_d  = (alu_result[WIDTH-1:0] == '0);
        state_d = WB;
      end
      WB: begin
        regs_d[rd_f] = wb_data;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      res_q     <= res_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      regs_q    <= regs_d;
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign alu_op      = (state_q == EXEC) ? op_f : '0;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign res_valid   = (state_q == WB);
  assign res_rd      = (state_q == WB) ? rd_f : '0;
  assign res_data    = (state_q == WB) ? wb_data : '0;
  assign carry_flag  = carry_q;
  assign zero_flag   = zero_q;
  assign illegal     = illegal_q;
  assign dbg_data    = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: a behavioural ALU drives alu_result, and a register/flag
// model predicts every writeback, flag, handshake timing and debug read.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [2:0]  alu_op;
  logic [14:0] alu_a, alu_b;
  logic [15:0] alu_result;
  logic        res_valid;
  logic [2:0]  res_rd;
  logic [14:0] res_data;
  logic        carry_flag, zero_flag, illegal;
  logic [2:0]  dbg_addr;
  logic [14:0] dbg_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int m_regs [8];
  bit m_c, m_z, m_ill;
  bit have_prev;
  int prev_nk, last_acc;

  alu_seq_ctrl #(.WIDTH(15), .OP_WIDTH(3), .NREGS(8)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .res_valid(res_valid), .res_rd(res_rd),
    .res_data(res_data), .carry_flag(carry_flag), .zero_flag(zero_flag),
    .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: 16-bit result, bit 15 is carry/borrow.
  always_comb begin
    case (alu_op)
      3'd1:    alu_result = {1'b0, alu_a} + {1'b0, alu_b};
      3'd2:    alu_result = {1'b0, alu_a} - {1'b0, alu_b};
      3'd3:    alu_result = {1'b0, alu_a & alu_b};
      3'd4:    alu_result = {1'b0, alu_a | alu_b};
      3'd5:    alu_result = {1'b0, alu_a ^ alu_b};
      default: alu_result = 16'h0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk(input int op, input int rd, input int rs1, input int rs2);
    logic [15:0] w;
    w = '0;
    w[15:13] = op[2:0]; w[12:10] = rd[2:0]; w[9:7] = rs1[2:0]; w[6:4] = rs2[2:0];
    return w;
  endfunction

  function automatic logic [15:0] mki(input int rd, input int imm);
    logic [15:0] w;
    w = '0;
    w[15:13] = 3'b110; w[12:10] = rd[2:0]; w[9:0] = imm[9:0];
    return w;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run(input logic [15:0] ins, input bit hold);
    int op, rd, a, b, r, old, busy, nk, acc;
    bit c, wr;
    op  = int'(ins[15:13]);
    rd  = int'(ins[12:10]);
    a   = m_regs[ins[9:7]];
    b   = m_regs[ins[6:4]];
    old = m_regs[rd];
    c = m_c; r = 0; wr = 1'b1;
    case (op)
      1: begin r = a + b; c = (r > 32767); r = r % 32768; end
      2: begin c = (a < b); r = (a - b) & 32'h7FFF; end
      3: begin r = a & b; c = 1'b0; end
      4: begin r = a | b; c = 1'b0; end
      5: begin r = a ^ b; c = 1'b0; end
      6: r = int'(ins[9:0]);
      default: wr = 1'b0;
    endcase
    busy = (op >= 1 && op <= 5) ? 3 : (op == 6) ? 2 : 0;
    nk   = (busy == 0) ? 2 : busy + 1;

    instr = ins; instr_valid = 1'b1; dbg_addr = ins[12:10];
    for (int t = 0; t < 8 && !instr_ready; t++) @(negedge clk);
    chk("ready_before_accept", instr_ready, 1);
    @(posedge clk);
    #1;
    acc = cyc;
    if (have_prev) chk("accept_interval", acc - last_acc, prev_nk);
    if (!hold) instr_valid = 1'b0;

    for (int k = 1; k <= nk; k++) begin
      @(negedge clk);
      chk("alu_op", alu_op, (busy == 3 && k == 2) ? op : 0);
      if (busy == 3 && k == 2) begin
        chk("alu_a", alu_a, a);
        chk("alu_b", alu_b, b);
      end
      chk("instr_ready", instr_ready, (k > busy) ? 1 : 0);
      chk("res_valid", res_valid, (busy > 0 && k == busy) ? 1 : 0);
      if (busy > 0 && k == busy) begin
        chk("res_rd", res_rd, rd);
        chk("res_data", res_data, r);
        chk("dbg_old", dbg_data, old);
      end
    end
    if (op == 7) m_ill = 1'b1;
    if (busy == 3) begin m_c = c; m_z = (r == 0); end
    if (busy > 0 && wr) m_regs[rd] = r;
    chk("dbg_new", dbg_data, m_regs[rd]);
    chk("carry", carry_flag, m_c);
    chk("zero", zero_flag, m_z);
    chk("illegal", illegal, m_ill);
    have_prev = 1'b1; prev_nk = nk; last_acc = acc;
  endtask

  task automatic check_regs(input string tag);
    instr_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dbg_addr = i[2:0];
      #1;
      chk(tag, dbg_data, m_regs[i]);
    end
    @(negedge clk);
    have_prev = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; dbg_addr = '0;
    have_prev = 1'b0; prev_nk = 0; last_acc = 0;
    m_c = 0; m_z = 0; m_ill = 0;
    for (int i = 0; i < 8; i++) m_regs[i] = 0;

    @(negedge clk);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_rd", res_rd, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_flags", {carry_flag, zero_flag, illegal}, 0);
    chk("rst_ready", instr_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: ADD of two immediates
    run(mki(1, 10'h3FF), 0);
    run(mki(2, 10'h001), 0);
    run(mk(1, 3, 1, 2), 0);
    dbg_addr = 3'd3; #1;
    chk("t1_dbg_r3", dbg_data, 15'h400);
    check_regs("t1_regs");

    // Test 2: SUB borrow, then XOR to zero
    run(mki(4, 5), 0);
    run(mki(5, 7), 0);
    run(mk(2, 6, 4, 5), 0);
    chk("t2_carry_borrow", carry_flag, 1);
    run(mk(5, 6, 4, 4), 0);
    chk("t2_zero", zero_flag, 1);

    // Test 3: build r1 = 0x7FFF, then ADD r1+r1 overflows
    run(mki(1, 10'h3FF), 0);
    for (int i = 0; i < 5; i++) run(mk(1, 1, 1, 1), 0);
    run(mki(2, 10'h01F), 0);
    run(mk(4, 1, 1, 2), 0);
    dbg_addr = 3'd1; #1;
    chk("t3_r1_max", dbg_data, 15'h7FFF);
    @(negedge clk);
    have_prev = 1'b0;
    run(mk(1, 1, 1, 1), 0);
    chk("t3_carry", carry_flag, 1);

    // Test 4: illegal then NOP
    run(mk(7, 2, 3, 4), 0);
    run(mk(0, 5, 1, 1), 0);
    check_regs("t4_regs");

    // Test 5: instr_valid held high across a dependent chain
    run(mki(1, 10'h155), 1);
    run(mk(1, 2, 1, 1), 1);
    run(mk(3, 3, 2, 1), 1);
    run(mk(4, 3, 3, 2), 1);
    run(mk(1, 3, 3, 3), 0);
    check_regs("t5_regs");

    // Test 6: reset during EXEC aborts the write
    instr = mk(1, 7, 1, 2); instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_exec_op", alu_op, 1);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) m_regs[i] = 0;
    m_c = 0; m_z = 0; m_ill = 0;
    chk("t6_res_valid", res_valid, 0);
    chk("t6_alu_op", alu_op, 0);
    chk("t6_flags", {carry_flag, zero_flag, illegal}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_ready", instr_ready, 1);
    chk("t6_no_wb", res_valid, 0);
    check_regs("t6_regs");

    // Randomized instruction stream against the model
    for (int n = 0; n < 60; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 3)
        run(mki($urandom_range(0, 7), $urandom_range(0, 1023)), bit'($urandom_range(0, 1)));
      else
        run(mk((sel == 9) ? $urandom_range(0, 7) : $urandom_range(1, 5),
               $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)),
            bit'($urandom_range(0, 1)));
    end
    check_regs("rand_regs");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle controller that drives the 3-bit-opcode, 15-bit-operand ALU and consumes its 16-bit result.
- Accepts 16-bit instructions over a valid/ready handshake and reads operands from an internal 8-entry register file.
- Issues the opcode and operands to the ALU, then writes the low 15 result bits back and updates carry, zero and illegal flags.
- Sits between the instruction source and the ALU as the issue/writeback stage.

Parameters:
- WIDTH, 15, operand and register width; ALU result is WIDTH+1 bits.
- OP_WIDTH, 3, ALU opcode width.
- NREGS, 8, register file depth; address width is 3.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- instr_valid  input  1  instruction offered.
- instr  input  16  [15:13] opcode, [12:10] rd, [9:7] rs1, [6:4] rs2, [9:0] imm for LOADI.
- instr_ready  output  1  block can accept an instruction.
- alu_op  output  OP_WIDTH  opcode to ALU.
- alu_a  output  WIDTH  ALU operand 1.
- alu_b  output  WIDTH  ALU operand 2.
- alu_result  input  WIDTH+1  combinational ALU result.
- res_valid  output  1  one-cycle pulse on register writeback.
- res_rd  output  3  destination of the writeback.
- res_data  output  WIDTH  value written.
- carry_flag  output  1  result bit 15 of the last ALU op.
- zero_flag  output  1  last ALU result[14:0] == 0.
- illegal  output  1  sticky; opcode 111 seen.
- dbg_addr  input  3  register file debug read address.
- dbg_data  output  WIDTH  combinational read of regs[dbg_addr].

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, all regs=0, all flags=0.
  - alu_op=000, alu_a=alu_b=0, res_valid=0, res_rd=0, res_data=0.
  - Reset mid-instruction aborts it with no write.
- States: IDLE, DECODE, EXEC, WB.
- instr_ready=1 only in IDLE. A transfer occurs on a clock edge with instr_valid&instr_ready; instr is latched.
- From IDLE on accept:
  - opcode 000 (NOP): stay in IDLE, no write, flags unchanged.
  - opcode 111: set illegal, stay in IDLE, no write.
  - opcode 001..110: go to DECODE.
- DECODE: latch alu_a=regs[rs1], alu_b=regs[rs2].
  - opcode 110 (LOADI): go to WB.
  - otherwise: go to EXEC.
- EXEC: alu_op=latched opcode for exactly this cycle and 000 in every other state.
  - At the end of EXEC, capture alu_result[15:0]; go to WB.
- WB: res_valid=1, res_rd=rd.
  - res_data = captured alu_result[14:0], or zero-extended imm[9:0] for LOADI.
  - regs[rd] updated at the end of WB; go to IDLE.
- Flags: updated only by ALU ops (001..101), at the end of EXEC.
  - carry_flag=alu_result[15]: carry for ADD, borrow (wrap) for SUB, 0 for logic ops.
  - zero_flag=(alu_result[14:0]==0).
  - LOADI, NOP and illegal leave both flags unchanged.
- Latency: accept at edge N; ALU op in cycle N+2; res_valid in cycle N+3 (N+2 for LOADI); next accept at edge N+4 (N+3 for LOADI).
- Hazards: none; the WB write completes before the next DECODE, so back-to-back dependent instructions see updated values.
- r0 is an ordinary writable register.
- alu_a and alu_b hold their last latched values outside DECODE/EXEC.
- dbg_data is combinational; it shows the old value during WB and the new value after the edge.
- illegal clears only on reset.
- instr_valid while not ready is ignored; the instruction is not consumed.

Test Plan:
1. LOADI r1=0x3FF, LOADI r2=0x001, ADD r3=r1+r2 -> alu_op=001 for one cycle, res_data=0x400, res_rd=3, carry=0, zero=0; dbg_addr=3 reads 0x400.
2. LOADI r4=5, LOADI r5=7, SUB r6=r4-r5 -> res_data=0x7FFE, carry=1, zero=0; then XOR r6=r4^r4 -> res_data=0, zero=1, carry=0.
3. Set r1=0x7FFF via repeated ADDs of LOADI values (e.g. 0x3FF accumulations), then ADD r1+r1 -> res_data=0x7FFE, carry=1; verify carry by comparison against a model.
4. Opcode 111 then NOP -> illegal=1 and stays set, no res_valid, flags and regs unchanged, instr_ready returns to 1 the next cycle.
5. Hold instr_valid=1 continuously with ADD, AND, OR -> instr_ready pulses every 4 cycles and res_valid every 4 cycles; a dependent chain gives correct results.
6. Assert rst_n=0 during EXEC of an ADD -> no res_valid, all regs=0, flags=0, state IDLE, instr_ready=1 after release.
